// File: rtl/tpdf_dither.sv
// tpdf_dither: requantizes a signed sample stream to a narrower width using TPDF
// dither, round-half-up, optional first-order error feedback and output saturation.
module tpdf_dither #(
  parameter int INPUT_WIDTH   = 32,
  parameter int OUTPUT_WIDTH  = 24,
  parameter int RANDOM_WIDTH  = 32,
  parameter int NOISE_SHAPING = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [RANDOM_WIDTH-1:0] random_in,
  input  logic                    dither_en,
  input  logic [INPUT_WIDTH-1:0]  s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [OUTPUT_WIDTH-1:0] m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    clip
);

  localparam int D  = INPUT_WIDTH - OUTPUT_WIDTH;
  localparam int SW = INPUT_WIDTH + 3;

  localparam logic signed [SW-1:0] HALF     = SW'(1) <<< (D - 1);
  localparam logic signed [SW-1:0] TPDF_OFS = (SW'(1) <<< D) - SW'(1);
  localparam logic signed [SW-1:0] OUT_MAX  = (SW'(1) <<< (OUTPUT_WIDTH - 1)) - SW'(1);
  localparam logic signed [SW-1:0] OUT_MIN  = -(SW'(1) <<< (OUTPUT_WIDTH - 1));
  localparam logic signed [D:0]    ERR_HALF = (D + 1)'(1) <<< (D - 1);

  if (D < 1 || D > 16) begin : g_bad_width
    $fatal(1, "tpdf_dither: INPUT_WIDTH-OUTPUT_WIDTH must be in 1..16");
  end
  if (RANDOM_WIDTH < 2 * D) begin : g_bad_random
    $fatal(1, "tpdf_dither: RANDOM_WIDTH must be at least 2*(INPUT_WIDTH-OUTPUT_WIDTH)");
  end

  logic [D-1:0]         r1;
  logic [D-1:0]         r2;
  logic signed [SW-1:0] tpdf;
  logic signed [SW-1:0] fb;
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] q;
  logic signed [D:0]    err;
  logic signed [D:0]    err_next;
  logic                 sat_hi;
  logic                 sat_lo;
  logic                 accept;
  logic                 unused_bits;

  assign s_ready = !m_valid || m_ready;
  assign accept  = s_valid && s_ready;
  assign r1      = random_in[D-1:0];
  assign r2      = random_in[2*D-1:D];

  // The sum is kept three bits wider than the input so dither, rounding offset
  // and feedback can never wrap before the floor shift and saturation.
  always_comb begin
    tpdf = '0;
    if (dither_en) begin
      tpdf = SW'(r1) + SW'(r2) - TPDF_OFS;
    end
    fb       = (NOISE_SHAPING != 0) ? SW'(err) : '0;
    sum      = SW'($signed(s_data)) + tpdf + HALF - fb;
    q        = sum >>> D;
    sat_hi   = q > OUT_MAX;
    sat_lo   = q < OUT_MIN;
    err_next = $signed({1'b0, sum[D-1:0]}) - ERR_HALF;
  end

  assign unused_bits = ^{random_in, sum, q, err_next};

  // Single output register; a clipped sample resets the feedback error so a
  // saturation event cannot be smeared into the following samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      clip    <= 1'b0;
      err     <= '0;
    end else if (accept) begin
      m_valid <= 1'b1;
      clip    <= sat_hi || sat_lo;
      if (sat_hi) begin
        m_data <= OUT_MAX[OUTPUT_WIDTH-1:0];
      end else if (sat_lo) begin
        m_data <= OUT_MIN[OUTPUT_WIDTH-1:0];
      end else begin
        m_data <= q[OUTPUT_WIDTH-1:0];
      end
      if (NOISE_SHAPING != 0) begin
        err <= (sat_hi || sat_lo) ? '0 : err_next;
      end
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tpdf_dither.sv
// Scoreboard bench for tpdf_dither: a plain instance and a noise-shaping instance
// share all inputs and are checked against an integer model of the requantizer.
module tb_tpdf_dither;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] random_in;
  logic        dither_en;
  logic [31:0] s_data;
  logic        s_valid;
  logic        m_ready;
  logic        s_ready, ns_s_ready;
  logic [23:0] m_data, ns_m_data;
  logic        m_valid, ns_m_valid;
  logic        clip, ns_clip;

  typedef struct packed {
    logic [23:0] d;
    logic        c;
  } exp_t;

  exp_t   q0[$];
  exp_t   q1[$];
  longint mdl_err;
  int     tests;
  int     failures;
  logic [23:0] obs_d;
  logic        obs_c;

  always #5 clk = ~clk;

  tpdf_dither #(.INPUT_WIDTH(32), .OUTPUT_WIDTH(24), .RANDOM_WIDTH(32), .NOISE_SHAPING(0)) dut (
    .clk(clk), .rst_n(rst_n), .random_in(random_in), .dither_en(dither_en),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .clip(clip)
  );

  tpdf_dither #(.INPUT_WIDTH(32), .OUTPUT_WIDTH(24), .RANDOM_WIDTH(32), .NOISE_SHAPING(1)) dut_ns (
    .clk(clk), .rst_n(rst_n), .random_in(random_in), .dither_en(dither_en),
    .s_data(s_data), .s_valid(s_valid), .s_ready(ns_s_ready),
    .m_data(ns_m_data), .m_valid(ns_m_valid), .m_ready(m_ready), .clip(ns_clip)
  );

  // Integer reference of one requantization step with D = 8.
  function automatic void model(input logic [31:0] s, input logic [31:0] rnd, input bit den,
                                input bit ns, input longint err_in,
                                output exp_t e, output longint err_out);
    longint tp, sm, q, fb;
    tp = den ? (longint'(rnd[7:0]) + longint'(rnd[15:8]) - 255) : 0;
    fb = ns ? err_in : 0;
    sm = longint'($signed(s)) + tp + 128 - fb;
    q  = sm >>> 8;
    err_out = ns ? ((sm & 255) - 128) : 0;
    if (q > 8388607) begin
      e.d = 24'h7FFFFF; e.c = 1'b1; err_out = 0;
    end else if (q < -8388608) begin
      e.d = 24'h800000; e.c = 1'b1; err_out = 0;
    end else begin
      e.d = q[23:0]; e.c = 1'b0;
    end
  endfunction

  // One clock of scoreboard bookkeeping; called at a falling edge with inputs driven.
  task automatic cycle(output bit ia, output bit oa);
    exp_t   e;
    longint dummy;
    #1;
    ia = s_valid && s_ready;
    oa = m_valid && m_ready;
    tests++;
    if (m_valid !== ns_m_valid || s_ready !== ns_s_ready) begin
      failures++;
      $display("[TB] FAIL handshake: m_valid %b/%b s_ready %b/%b, instances must agree",
               m_valid, ns_m_valid, s_ready, ns_s_ready);
    end
    if (oa) begin
      obs_d = m_data;
      obs_c = clip;
      tests++;
      if (q0.size() == 0) begin
        failures++;
        $display("[TB] FAIL plain_extra_output: got %h clip %b, expected no output", m_data, clip);
      end else begin
        e = q0.pop_front();
        if ({m_data, clip} !== {e.d, e.c}) begin
          failures++;
          $display("[TB] FAIL plain_output: got %h clip %b, expected %h clip %b", m_data, clip, e.d, e.c);
        end
      end
      tests++;
      if (q1.size() == 0) begin
        failures++;
        $display("[TB] FAIL ns_extra_output: got %h clip %b, expected no output", ns_m_data, ns_clip);
      end else begin
        e = q1.pop_front();
        if ({ns_m_data, ns_clip} !== {e.d, e.c}) begin
          failures++;
          $display("[TB] FAIL ns_output: got %h clip %b, expected %h clip %b", ns_m_data, ns_clip, e.d, e.c);
        end
      end
    end
    if (ia) begin
      model(s_data, random_in, dither_en, 1'b0, 0, e, dummy);
      q0.push_back(e);
      model(s_data, random_in, dither_en, 1'b1, mdl_err, e, mdl_err);
      q1.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic send_one(input logic [31:0] s, input bit den, input logic [31:0] rnd);
    bit ia, oa;
    int n;
    n = 0;
    s_valid = 1'b1; s_data = s; dither_en = den; random_in = rnd;
    do begin
      cycle(ia, oa);
      n++;
    end while (!ia && n < 20);
    s_valid = 1'b0;
    if (!ia) begin
      tests++; failures++;
      $display("[TB] FAIL send_timeout: sample %h not accepted within 20 cycles", s);
    end
  endtask

  task automatic drain();
    bit ia, oa;
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 20) begin
      cycle(ia, oa);
      n++;
    end
    tests++;
    if (q0.size() != 0 || q1.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain_timeout: %0d/%0d outputs still pending, expected 0", q0.size(), q1.size());
    end
  endtask

  task automatic test_reset();
    tests++;
    if (m_valid !== 1'b0 || m_data !== 24'h0 || clip !== 1'b0 ||
        ns_m_valid !== 1'b0 || ns_m_data !== 24'h0 || ns_clip !== 1'b0 || dut_ns.err !== 9'sd0) begin
      failures++;
      $display("[TB] FAIL reset_state: valid %b data %h clip %b err %0d, expected 0 0 0 0",
               m_valid, m_data, clip, dut_ns.err);
    end
  endtask

  task automatic test_round();
    send_one(32'h0000_0180, 1'b0, 32'h0);
    tests++;
    if (m_valid !== 1'b1 || m_data !== 24'h000002 || clip !== 1'b0) begin
      failures++;
      $display("[TB] FAIL round_0x180: valid %b data %h clip %b, expected 1 000002 0", m_valid, m_data, clip);
    end
    send_one(32'h0000_017F, 1'b0, 32'h0);
    send_one(32'hFFFF_FF80, 1'b0, 32'h0);
    send_one(32'hFFFF_FF7F, 1'b0, 32'h0);
    tests++;
    if (m_data !== 24'hFFFFFF) begin
      failures++;
      $display("[TB] FAIL round_neg: data %h, expected ffffff", m_data);
    end
    send_one(32'h0012_3480, 1'b1, 32'h0000_A37F);
    drain();
  endtask

  task automatic test_clip();
    send_one(32'h7FFF_FFF0, 1'b0, 32'h0);
    tests++;
    if (m_data !== 24'h7FFFFF || clip !== 1'b1) begin
      failures++;
      $display("[TB] FAIL clip_max: data %h clip %b, expected 7fffff 1", m_data, clip);
    end
    send_one(32'h8000_0000, 1'b1, 32'h0);
    tests++;
    if (m_data !== 24'h800000 || clip !== 1'b1) begin
      failures++;
      $display("[TB] FAIL clip_min: data %h clip %b, expected 800000 1", m_data, clip);
    end
    send_one(32'h7FFF_FF7F, 1'b0, 32'h0);
    tests++;
    if (m_data !== 24'h7FFFFF || clip !== 1'b0) begin
      failures++;
      $display("[TB] FAIL clip_edge: data %h clip %b, expected 7fffff 0", m_data, clip);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3];
    int idx, cyc, outs;
    bit ia, oa;
    vals[0] = 32'h0000_0100; vals[1] = 32'h0000_0200; vals[2] = 32'h0000_0300;
    idx = 0; outs = 0; cyc = 0;
    dither_en = 1'b0; random_in = 32'h0;
    while ((idx < 3 || q0.size() != 0) && cyc < 40) begin
      s_valid = (idx < 3);
      s_data  = (idx < 3) ? vals[idx] : 32'h0;
      m_ready = (cyc >= 6);
      if (cyc >= 1 && cyc <= 5) begin
        #1;
        tests++;
        if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_data !== 24'h000001) begin
          failures++;
          $display("[TB] FAIL backpressure_hold: s_ready %b valid %b data %h, expected 0 1 000001",
                   s_ready, m_valid, m_data);
        end
      end
      cycle(ia, oa);
      if (ia) idx++;
      if (oa) outs++;
      cyc++;
    end
    s_valid = 1'b0; m_ready = 1'b1;
    tests++;
    if (outs != 3 || idx != 3) begin
      failures++;
      $display("[TB] FAIL backpressure_count: %0d in %0d out, expected 3 in 3 out", idx, outs);
    end
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b0;
    send_one(32'h1234_5678, 1'b0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (m_valid !== 1'b0 || m_data !== 24'h0 || clip !== 1'b0 ||
        ns_m_valid !== 1'b0 || ns_m_data !== 24'h0 || dut_ns.err !== 9'sd0) begin
      failures++;
      $display("[TB] FAIL async_reset: valid %b data %h clip %b err %0d, expected 0 0 0 0",
               m_valid, m_data, clip, dut_ns.err);
    end
    q0.delete(); q1.delete(); mdl_err = 0;
    @(negedge clk);
    rst_n = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    send_one(32'h0000_0180, 1'b0, 32'h0);
    tests++;
    if (m_valid !== 1'b1 || m_data !== 24'h000002) begin
      failures++;
      $display("[TB] FAIL after_reset: valid %b data %h, expected 1 000002", m_valid, m_data);
    end
    drain();
  endtask

  task automatic test_noise_shaping();
    for (int i = 0; i < 8; i++) begin
      send_one(32'h0000_0040, 1'b0, 32'h0);
      tests++;
      if (dut_ns.err !== 9'(mdl_err)) begin
        failures++;
        $display("[TB] FAIL ns_err_%0d: err %0d, expected %0d", i, dut_ns.err, mdl_err);
      end
    end
    for (int i = 0; i < 6; i++) send_one(32'h0000_0155 + 32'(i * 37), 1'b0, 32'h0);
    drain();
  endtask

  task automatic test_dither_stats();
    int sent, got, cyc, outside, clips, stalls;
    longint acc;
    real mean;
    bit ia, oa;
    sent = 0; got = 0; cyc = 0; outside = 0; clips = 0; stalls = 0; acc = 0;
    while (got < 4096 && cyc < 5000) begin
      s_valid = (sent < 4096); s_data = 32'h0; dither_en = 1'b1; random_in = $urandom;
      cycle(ia, oa);
      if (ia) sent++;
      else if (sent < 4096) stalls++;
      if (oa) begin
        got++;
        acc += longint'($signed(obs_d));
        if (obs_d != 24'h000000 && obs_d != 24'h000001 && obs_d != 24'hFFFFFF) outside++;
        if (obs_c) clips++;
      end
      cyc++;
    end
    s_valid = 1'b0;
    mean = real'(acc) / 4096.0;
    tests++;
    if (got != 4096 || stalls != 0) begin
      failures++;
      $display("[TB] FAIL dither_throughput: %0d outputs %0d stalls, expected 4096 0", got, stalls);
    end
    tests++;
    if (outside != 0 || clips != 0) begin
      failures++;
      $display("[TB] FAIL dither_range: %0d out of range %0d clipped, expected 0 0", outside, clips);
    end
    tests++;
    if (mean > 0.05 || mean < -0.05) begin
      failures++;
      $display("[TB] FAIL dither_mean: mean %f, expected within +/-0.05", mean);
    end
  endtask

  initial begin
    tests = 0; failures = 0; mdl_err = 0;
    rst_n = 1'b0; s_valid = 1'b0; s_data = 32'h0; dither_en = 1'b0; random_in = 32'h0; m_ready = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_round();
    test_clip();
    test_back_to_back();
    test_reset_mid();
    test_noise_shaping();
    test_dither_stats();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
